// File: rtl/qam16_mapper.sv
// Serial-to-16QAM symbol mapper: assembles 4-bit nibbles from a bit stream
// and presents Gray-mapped I/Q levels once per SPS-sample symbol period.
module qam16_mapper #(
    parameter int SPS = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [3:0] count,
    output logic [3:0] iout,
    output logic [3:0] qout,
    output logic       sym_valid,
    output logic       underflow,
    input  logic       clr_underflow
);

    localparam logic [3:0] LAST = 4'(SPS - 1);

    logic [3:0] count_q, count_d;
    logic [3:0] shift_q, shift_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [3:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [3:0] i_q, i_d;
    logic [3:0] q_q, q_d;
    logic       sv_q, sv_d;
    logic       uf_q, uf_d;

    logic       boundary;
    logic       accept;
    logic [3:0] new_nib;

    // Gray pair to signed level: 00->-3, 01->-1, 11->+1, 10->+3
    function automatic logic [3:0] map2(input logic [1:0] g);
        case (g)
            2'b00:   map2 = 4'b1101;
            2'b01:   map2 = 4'b1111;
            2'b11:   map2 = 4'b0001;
            default: map2 = 4'b0011;
        endcase
    endfunction

    assign boundary  = (count_q == LAST);
    // Stall only the 4th bit, and only while the hold slot cannot drain this edge
    assign bit_ready = !((bcnt_q == 2'd3) && hold_full_q && !boundary);
    assign accept    = bit_valid && bit_ready;
    assign new_nib   = {shift_q[2:0], bit_in};

    always_comb begin
        count_d     = boundary ? 4'd0 : count_q + 4'd1;
        shift_d     = shift_q;
        bcnt_d      = bcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        i_d         = i_q;
        q_d         = q_q;
        sv_d        = sv_q;
        uf_d        = uf_q;

        if (accept) begin
            shift_d = new_nib;
            bcnt_d  = bcnt_q + 2'd1;
        end

        if (boundary) begin
            if (hold_full_q) begin
                i_d         = map2(hold_q[3:2]);
                q_d         = map2(hold_q[1:0]);
                sv_d        = 1'b1;
                hold_full_d = 1'b0;
            end else begin
                i_d  = 4'd0;
                q_d  = 4'd0;
                sv_d = 1'b0;
            end
        end

        if (boundary && !hold_full_q)
            uf_d = 1'b1;
        else if (clr_underflow)
            uf_d = 1'b0;

        // A completing nibble refills the slot even if it drained this same edge
        if (accept && bcnt_q == 2'd3) begin
            hold_d      = new_nib;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= 4'd0;
            shift_q     <= 4'd0;
            bcnt_q      <= 2'd0;
            hold_q      <= 4'd0;
            hold_full_q <= 1'b0;
            i_q         <= 4'd0;
            q_q         <= 4'd0;
            sv_q        <= 1'b0;
            uf_q        <= 1'b0;
        end else begin
            count_q     <= count_d;
            shift_q     <= shift_d;
            bcnt_q      <= bcnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            i_q         <= i_d;
            q_q         <= q_d;
            sv_q        <= sv_d;
            uf_q        <= uf_d;
        end
    end

    assign count     = count_q;
    assign iout      = i_q;
    assign qout      = q_q;
    assign sym_valid = sv_q;
    assign underflow = uf_q;

endmodule

// File: doc/qam16_mapper.md
QAM16_MAPPER -- requirements
Module: qam16_mapper

Interface
REQ-001 Parameter SPS, default 11: samples per symbol; count runs 0..SPS-1; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately; released synchronously to clk by the system.
REQ-004 bit_in  input  1  serial payload bit, MSB of each nibble first.
REQ-005 bit_valid  input  1  bit_in is valid this cycle.
REQ-006 bit_ready  output  1  block accepts bit_in this cycle; a bit transfers when bit_valid and bit_ready are both 1 at a rising edge.
REQ-007 count  output  4  symbol-phase counter 0..SPS-1, consumed by the upsampler (phase 0 = symbol sample).
REQ-008 iout  output  4 signed  in-phase level of current symbol.
REQ-009 qout  output  4 signed  quadrature level of current symbol.
REQ-010 sym_valid  output  1  iout/qout carry a real symbol (0 = idle/underflow zeros).
REQ-011 underflow  output  1  sticky: a symbol boundary occurred with no nibble ready.
REQ-012 clr_underflow  input  1  synchronous clear of underflow.

Function
REQ-013 count SHALL increment by 1 each cycle, wrapping SPS-1 -> 0, free-running from 0 after reset release.
REQ-014 Bit assembler: 4-bit shift register plus 2-bit bit counter; each accepted bit shifts in at LSB; first accepted bit of a nibble becomes b3.
REQ-015 On the 4th accepted bit, the completed nibble {b3,b2,b1,b0} SHALL be written to a one-entry holding register (hold_full <= 1) and the bit counter SHALL return to 0.
REQ-016 bit_ready SHALL be 0 only when bit counter = 3, hold_full = 1 and count != SPS-1; otherwise 1 (combinational from registers).
REQ-017 Symbol load: on the edge where count = SPS-1, if hold_full, iout/qout <= mapped nibble, sym_valid <= 1, hold_full <= 0; new values are therefore stable throughout the count = 0 cycle.
REQ-018 If hold_full = 0 at that edge: iout = qout = 0, sym_valid <= 0, underflow <= 1.
REQ-019 Simultaneous hold consume and 4th-bit completion at count = SPS-1: the old nibble is loaded to outputs, the new nibble is written to hold, hold_full stays 1.
REQ-020 iout/qout/sym_valid SHALL hold their value for all SPS cycles between loads.
REQ-021 Mapping (Gray): b3b2 -> iout, b1b0 -> qout; 00 -> -3 (4'b1101), 01 -> -1 (4'b1111), 11 -> +1 (4'b0001), 10 -> +3 (4'b0011).
REQ-022 Outputs SHALL only ever take values in {-3,-1,0,+1,+3}.
REQ-023 clr_underflow SHALL clear underflow at the next edge; if a new underflow event occurs in the same cycle, set wins.
REQ-024 bit_valid with bit_ready = 0 SHALL not change assembler state; bit_in is ignored.

Reset
REQ-025 While reset = 0: count = 0, iout = 0, qout = 0, sym_valid = 0, underflow = 0, shift register = 0, bit counter = 0, hold_full = 0; bit_ready = 1.
REQ-026 Reset asserted mid-nibble or mid-symbol SHALL discard partial bits and held nibble; after release count restarts at 0 and the first full symbol boundary is at count = SPS-1.

Verification
REQ-027 After reset release with bit_valid = 0 for 22 cycles -> count sequence 0..10,0..10; iout = qout = 0; sym_valid = 0; underflow = 1 from cycle 11.
REQ-028 Feed bits 1,0,0,1 (nibble 1001) within first 10 cycles -> at count = 0 of second period iout = +3 (0011), qout = -1 (1111), sym_valid = 1, held 11 cycles.
REQ-029 Stream 8 bits back-to-back (0000,1111) from reset -> bit_ready drops on 8th bit until count = 10; symbols -3/-3 then +1/+1 appear on consecutive periods.
REQ-030 4th bit of second nibble arrives exactly at count = 10 with hold full -> bit accepted, outputs load first nibble, second nibble loads at next boundary.
REQ-031 Assert reset after 2 bits of a nibble, release, feed 0110 -> outputs -1/+3; no stale bits appear.
REQ-032 With underflow = 1 pulse clr_underflow while bits keep hold full -> underflow = 0 next cycle and stays 0.
